// File: rtl/hc139_scan_demux_if.sv
// Bus bundle for hc139_scan_demux: disable/data inputs, select pair, channel outputs, frame strobe.
interface hc139_scan_demux_if #(
   parameter int unsigned WIDTH = 1
);
   logic             E;
   logic [WIDTH-1:0] D;
   logic             S1;
   logic             S0;
   logic [WIDTH-1:0] Q0;
   logic [WIDTH-1:0] Q1;
   logic [WIDTH-1:0] Q2;
   logic [WIDTH-1:0] Q3;
   logic             FRAME;

   // master drives disable and returned data; slave is the demultiplexer
   modport master (output E, D, input S1, S0, Q0, Q1, Q2, Q3, FRAME);
   modport slave  (input E, D, output S1, S0, Q0, Q1, Q2, Q3, FRAME);
endinterface

// File: rtl/hc139_scan_demux.sv
// Four-channel time-division demux: drives S1/S0, samples D after DWELL cycles into Q0..Q3, pulses FRAME per scan.
// Optional macro HC139_SCAN_CLEAR_ON_DISABLE_EN: when defined, Q0..Q3 clear while E=1; otherwise they hold.
module hc139_scan_demux #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DWELL = 2
) (
   input logic                CLK,
   input logic                RST,
   hc139_scan_demux_if.slave  bus
);
   localparam int unsigned DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [1:0]       r_sel;
   logic [DCW-1:0]   r_dcnt;
   logic [WIDTH-1:0] r_q [4];
   logic             r_frame;
   logic             w_last;

   // last dwell cycle on the current select code: sample now
   assign w_last = (r_dcnt == DCW'(DWELL - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sel   <= 2'd0;
         r_dcnt  <= '0;
         r_frame <= 1'b0;
         for (int i = 0; i < 4; i++) r_q[i] <= '0;
      end else begin
         r_frame <= 1'b0;
         if (bus.E) begin
            // halted: select parked on channel 0, disable beats any pending capture
            r_sel  <= 2'd0;
            r_dcnt <= '0;
`ifdef HC139_SCAN_CLEAR_ON_DISABLE_EN
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
`endif
         end else if (w_last) begin
            r_q[r_sel] <= bus.D;
            r_dcnt     <= '0;
            r_sel      <= r_sel + 2'd1;
            r_frame    <= (r_sel == 2'd3);
         end else begin
            r_dcnt <= r_dcnt + DCW'(1);
         end
      end
   end

   assign bus.S1    = r_sel[1];
   assign bus.S0    = r_sel[0];
   assign bus.Q0    = r_q[0];
   assign bus.Q1    = r_q[1];
   assign bus.Q2    = r_q[2];
   assign bus.Q3    = r_q[3];
   assign bus.FRAME = r_frame;
endmodule

// File: tb/tb_hc139_scan_demux.sv
// Self-checking bench: two demux instances (DWELL=2 and DWELL=1) against an arithmetic reference model.
module tb_hc139_scan_demux;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hc139_scan_demux_if #(.WIDTH(4)) ifa ();
   hc139_scan_demux_if #(.WIDTH(4)) ifb ();

   hc139_scan_demux #(.WIDTH(4), .DWELL(2)) u_a (.CLK(clk), .RST(rst), .bus(ifa.slave));
   hc139_scan_demux #(.WIDTH(4), .DWELL(1)) u_b (.CLK(clk), .RST(rst), .bus(ifb.slave));

   int errs   = 0;
   int checks = 0;

   // model: run = consecutive enabled edges since last disable/reset
   int         dw [2] = '{2, 1};
   int         run [2];
   logic [3:0] mq [2][4];
   logic       mframe [2];

   typedef struct {
      logic       e;
      logic [3:0] d;
      logic [1:0] sel;
      logic       frame;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         run[k] = 0;
         mframe[k] = 1'b0;
         for (int c = 0; c < 4; c++) mq[k][c] = 4'd0;
      end
   endtask

   task automatic mstep(input int k, input logic e, input logic [3:0] d);
      int ch;
      mframe[k] = 1'b0;
      if (e) begin
         run[k] = 0;
`ifdef HC139_SCAN_CLEAR_ON_DISABLE_EN
         for (int c = 0; c < 4; c++) mq[k][c] = 4'd0;
`endif
      end else begin
         run[k]++;
         if (run[k] % dw[k] == 0) begin
            ch = (run[k] / dw[k] - 1) % 4;
            mq[k][ch] = d;
            if (ch == 3) mframe[k] = 1'b1;
         end
      end
   endtask

   function automatic int msel(input int k);
      return (run[k] / dw[k]) % 4;
   endfunction

   task automatic cmp_all(input int k);
      int s, q0, q1, q2, q3, fr;
      if (k == 0) begin
         s = int'({ifa.S1, ifa.S0}); q0 = int'(ifa.Q0); q1 = int'(ifa.Q1);
         q2 = int'(ifa.Q2); q3 = int'(ifa.Q3); fr = int'(ifa.FRAME);
      end else begin
         s = int'({ifb.S1, ifb.S0}); q0 = int'(ifb.Q0); q1 = int'(ifb.Q1);
         q2 = int'(ifb.Q2); q3 = int'(ifb.Q3); fr = int'(ifb.FRAME);
      end
      chk($sformatf("dut%0d sel", k), s, msel(k));
      chk($sformatf("dut%0d q0", k), q0, int'(mq[k][0]));
      chk($sformatf("dut%0d q1", k), q1, int'(mq[k][1]));
      chk($sformatf("dut%0d q2", k), q2, int'(mq[k][2]));
      chk($sformatf("dut%0d q3", k), q3, int'(mq[k][3]));
      chk($sformatf("dut%0d frame", k), fr, int'(mframe[k]));
   endtask

   task automatic tick(input logic ea, input logic [3:0] da, input logic eb, input logic [3:0] db);
      ifa.E = ea; ifa.D = da;
      ifb.E = eb; ifb.D = db;
      @(posedge clk);
      mstep(0, ea, da);
      mstep(1, eb, db);
      #1;
      cmp_all(0);
      cmp_all(1);
   endtask

   initial begin
      logic [3:0] pat [4];
      logic [3:0] saved [4];
      int         frames [$];
      int         n;

      pat = '{4'hA, 4'hB, 4'hC, 4'hD};
      tbl[0] = '{1'b0, 4'd1, 2'd1, 1'b0};
      tbl[1] = '{1'b0, 4'd2, 2'd2, 1'b0};
      tbl[2] = '{1'b0, 4'd3, 2'd3, 1'b0};
      tbl[3] = '{1'b0, 4'd4, 2'd0, 1'b1};
      tbl[4] = '{1'b0, 4'd5, 2'd1, 1'b0};
      tbl[5] = '{1'b0, 4'd6, 2'd2, 1'b0};
      tbl[6] = '{1'b0, 4'd7, 2'd3, 1'b0};
      tbl[7] = '{1'b0, 4'd8, 2'd0, 1'b1};

      ifa.E = 1'b1; ifa.D = 4'd0;
      ifb.E = 1'b1; ifb.D = 4'd0;
      mreset();
      #2;
      cmp_all(0);
      cmp_all(1);
      #1 rst = 1'b0;

      // DWELL=1 table: one capture per cycle, FRAME on 4th and 8th edge
      tick(1'b1, 4'd0, 1'b1, 4'd0);
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 4'd0, tbl[i].e, tbl[i].d);
         chk($sformatf("tbl[%0d] sel", i), int'({ifb.S1, ifb.S0}), int'(tbl[i].sel));
         chk($sformatf("tbl[%0d] frame", i), int'(ifb.FRAME), int'(tbl[i].frame));
      end
      chk("tbl q0", int'(ifb.Q0), 5);
      chk("tbl q1", int'(ifb.Q1), 6);
      chk("tbl q2", int'(ifb.Q2), 7);
      chk("tbl q3", int'(ifb.Q3), 8);

      // basic scan on DWELL=2: D follows the select; FRAME every 8 edges
      for (int i = 1; i <= 24; i++) begin
         tick(1'b0, pat[msel(0)], 1'b1, 4'd0);
         if (ifa.FRAME) frames.push_back(i);
      end
      chk("scan q0", int'(ifa.Q0), 4'hA);
      chk("scan q1", int'(ifa.Q1), 4'hB);
      chk("scan q2", int'(ifa.Q2), 4'hC);
      chk("scan q3", int'(ifa.Q3), 4'hD);
      chk("scan frame count", frames.size(), 3);
      for (int i = 0; i < frames.size(); i++)
         chk($sformatf("scan frame[%0d] edge", i), frames[i], 8 * (i + 1));

      // disable after Q0 and Q1 captured, then restart into Q0
      tick(1'b1, 4'd0, 1'b1, 4'd0);
      for (int i = 0; i < 4; i++) tick(1'b0, 4'd3 + 4'(i), 1'b1, 4'd0);
      tick(1'b1, 4'd9, 1'b1, 4'd0);
      chk("dis sel", int'({ifa.S1, ifa.S0}), 0);
      chk("dis frame", int'(ifa.FRAME), 0);
      tick(1'b0, 4'd5, 1'b1, 4'd0);
      chk("restart no early capture", int'({ifa.S1, ifa.S0}), 0);
      tick(1'b0, 4'd5, 1'b1, 4'd0);
      chk("restart q0", int'(ifa.Q0), 5);
      chk("restart sel", int'({ifa.S1, ifa.S0}), 1);

      // disable on the very edge that would capture Q3
      n = 0;
      while (run[0] % 8 != 7 && n < 16) begin
         tick(1'b0, 4'd6, 1'b1, 4'd0);
         n++;
      end
      chk("align budget", int'(run[0] % 8), 7);
      for (int c = 0; c < 4; c++) saved[c] = mq[0][c];
      tick(1'b1, 4'hF, 1'b1, 4'd0);
      chk("simul frame", int'(ifa.FRAME), 0);
`ifdef HC139_SCAN_CLEAR_ON_DISABLE_EN
      chk("simul q3", int'(ifa.Q3), 0);
      chk("cfg q0", int'(ifa.Q0), 0);
      chk("cfg q1", int'(ifa.Q1), 0);
`else
      chk("simul q3", int'(ifa.Q3), int'(saved[3]));
      chk("cfg q0", int'(ifa.Q0), int'(saved[0]));
      chk("cfg q1", int'(ifa.Q1), int'(saved[1]));
`endif

      // randomized run on both instances
      for (int i = 0; i < 400; i++)
         tick($urandom_range(0, 9) == 0, 4'($urandom), $urandom_range(0, 9) == 0, 4'($urandom));

      // async reset mid-run with Q0=1 and select 10
      tick(1'b1, 4'd0, 1'b1, 4'd0);
      for (int i = 0; i < 4; i++) tick(1'b0, 4'd1, 1'b0, 4'd1);
      chk("pre-rst q0", int'(ifa.Q0), 1);
      chk("pre-rst sel", int'({ifa.S1, ifa.S0}), 2);
      #2 rst = 1'b1;
      mreset();
      #1;
      cmp_all(0);
      cmp_all(1);
      @(negedge clk);
      rst = 1'b0;
      tick(1'b0, 4'd2, 1'b0, 4'd2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
